tlc5615_driver: RTL and testbench



---
 rtl/tlc5615_pkg.sv | 16 +
 rtl/tlc5615_driver_dac_phase_timer.sv | 33 +++
 rtl/tlc5615_driver.sv | 159 +++++++++++++++
 tb/tb_tlc5615_driver.sv | 323 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/tlc5615_pkg.sv
// Shared types and frame geometry for the TLC5615 DAC serial writer.
package tlc5615_pkg;

  localparam int unsigned DAC_BITS   = 10;
  localparam int unsigned FRAME_BITS = 12;
  localparam int unsigned FILL_BITS  = 2;
  localparam int unsigned BIT_CNT_W  = 4;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_HOLD  = 2'd2,
    ST_GAP   = 2'd3
  } state_t;

endpackage

// File: rtl/tlc5615_driver_dac_phase_timer.sv
// Half-period timer: one-cycle tick every CLK_DIV cycles while run is high,
// count restarts from zero whenever run rises.
module dac_phase_timer #(
  parameter int unsigned CLK_DIV = 25
) (
  input  logic clk,
  input  logic reset,
  input  logic run,
  output logic tick
);

  localparam int unsigned CW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  logic [CW-1:0] r_cnt;
  logic          r_tick;

  // Tick is registered one count early so it lands in the last cycle of each phase.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_cnt  <= '0;
      r_tick <= 1'b0;
    end else if (!run) begin
      r_cnt  <= '0;
      r_tick <= 1'b0;
    end else begin
      r_tick <= (r_cnt == CW'(CLK_DIV - 2));
      r_cnt  <= (r_cnt == CW'(CLK_DIV - 1)) ? '0 : r_cnt + CW'(1);
    end
  end

  assign tick = r_tick;

endmodule

// File: rtl/tlc5615_driver.sv
// TLC5615 serial writer: frames a 10-bit code as 12 bits on CS_N/SCLK/DIN.
// Optional TLC5615_SKIP_SAME_EN suppresses frames that repeat the last code.
module tlc5615_driver
  import tlc5615_pkg::*;
#(
  parameter int unsigned CLK_DIV = 25
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [DAC_BITS-1:0] din,
  input  logic                start,
  output logic                ready,
  output logic                done,
  output logic                dac_cs_n,
  output logic                dac_sclk,
  output logic                dac_din
);

  state_t                r_state, w_state_nxt;
  logic [FRAME_BITS-1:0] r_shift, w_shift_nxt;
  logic [BIT_CNT_W-1:0]  r_bit_cnt, w_bit_cnt_nxt;
  logic                  r_phase, w_phase_nxt;
  logic                  r_cs_n, w_cs_n_nxt;
  logic                  r_sclk, w_sclk_nxt;
  logic                  r_din, w_din_nxt;
  logic                  r_ready, w_ready_nxt;
  logic                  r_done, w_done_nxt;
  logic                  w_run;
  logic                  w_tick;
  logic                  w_skip;

  assign w_run = (r_state != ST_IDLE);

  dac_phase_timer #(
    .CLK_DIV(CLK_DIV)
  ) u_timer (
    .clk  (clk),
    .reset(reset),
    .run  (w_run),
    .tick (w_tick)
  );

`ifdef TLC5615_SKIP_SAME_EN
  logic [DAC_BITS-1:0] r_last;
  logic [DAC_BITS-1:0] r_cur;
  logic                r_last_vld;

  // Last code is only committed once its frame has fully completed.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_last     <= '0;
      r_cur      <= '0;
      r_last_vld <= 1'b0;
    end else begin
      if (r_state == ST_IDLE && start && !w_skip) r_cur <= din;
      if (r_state == ST_GAP && w_tick) begin
        r_last     <= r_cur;
        r_last_vld <= 1'b1;
      end
    end
  end

  assign w_skip = r_last_vld && (din == r_last);
`else
  assign w_skip = 1'b0;
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state   <= ST_IDLE;
      r_shift   <= '0;
      r_bit_cnt <= '0;
      r_phase   <= 1'b0;
      r_cs_n    <= 1'b1;
      r_sclk    <= 1'b0;
      r_din     <= 1'b0;
      r_ready   <= 1'b1;
      r_done    <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_shift   <= w_shift_nxt;
      r_bit_cnt <= w_bit_cnt_nxt;
      r_phase   <= w_phase_nxt;
      r_cs_n    <= w_cs_n_nxt;
      r_sclk    <= w_sclk_nxt;
      r_din     <= w_din_nxt;
      r_ready   <= w_ready_nxt;
      r_done    <= w_done_nxt;
    end
  end

  always_comb begin
    w_state_nxt   = r_state;
    w_shift_nxt   = r_shift;
    w_bit_cnt_nxt = r_bit_cnt;
    w_phase_nxt   = r_phase;
    w_cs_n_nxt    = r_cs_n;
    w_sclk_nxt    = r_sclk;
    w_din_nxt     = r_din;
    w_ready_nxt   = r_ready;
    w_done_nxt    = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (start && w_skip) begin
          w_done_nxt = 1'b1;
        end else if (start) begin
          w_shift_nxt   = {din, {FILL_BITS{1'b0}}};
          w_bit_cnt_nxt = '0;
          w_phase_nxt   = 1'b0;
          w_cs_n_nxt    = 1'b0;
          w_sclk_nxt    = 1'b0;
          w_din_nxt     = din[DAC_BITS-1];
          w_ready_nxt   = 1'b0;
          w_state_nxt   = ST_SHIFT;
        end
      end
      ST_SHIFT: begin
        // Data only moves at the end of a high phase, i.e. start of the next low phase.
        if (w_tick) begin
          if (!r_phase) begin
            w_sclk_nxt  = 1'b1;
            w_phase_nxt = 1'b1;
          end else if (r_bit_cnt == BIT_CNT_W'(FRAME_BITS - 1)) begin
            w_sclk_nxt  = 1'b0;
            w_state_nxt = ST_HOLD;
          end else begin
            w_sclk_nxt    = 1'b0;
            w_phase_nxt   = 1'b0;
            w_bit_cnt_nxt = r_bit_cnt + BIT_CNT_W'(1);
            w_shift_nxt   = {r_shift[FRAME_BITS-2:0], 1'b0};
            w_din_nxt     = r_shift[FRAME_BITS-2];
          end
        end
      end
      ST_HOLD: begin
        if (w_tick) begin
          w_cs_n_nxt  = 1'b1;
          w_din_nxt   = 1'b0;
          w_state_nxt = ST_GAP;
        end
      end
      ST_GAP: begin
        if (w_tick) begin
          w_done_nxt  = 1'b1;
          w_ready_nxt = 1'b1;
          w_state_nxt = ST_IDLE;
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  assign ready    = r_ready;
  assign done     = r_done;
  assign dac_cs_n = r_cs_n;
  assign dac_sclk = r_sclk;
  assign dac_din  = r_din;

endmodule

// File: tb/tb_tlc5615_driver.sv
// Self-checking bench for tlc5615_driver at CLK_DIV=25 and CLK_DIV=2.
module tb_tlc5615_driver;

  localparam int D1 = 25;
  localparam int D2 = 2;

  logic       clk = 1'b0;
  logic       reset;
  logic [9:0] din, din2;
  logic       start, start2;
  logic       ready, done, cs_n, sclk, sdi;
  logic       ready2, done2, cs_n2, sclk2, sdi2;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;
  int frame_t0 = 0;
  logic [9:0] last_code = '0;
  logic       last_vld  = 1'b0;

  always #10 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  tlc5615_driver #(.CLK_DIV(D1)) dut (
    .clk(clk), .reset(reset), .din(din), .start(start), .ready(ready), .done(done),
    .dac_cs_n(cs_n), .dac_sclk(sclk), .dac_din(sdi)
  );

  tlc5615_driver #(.CLK_DIV(D2)) dut2 (
    .clk(clk), .reset(reset), .din(din2), .start(start2), .ready(ready2), .done(done2),
    .dac_cs_n(cs_n2), .dac_sclk(sclk2), .dac_din(sdi2)
  );

  // Expected {cs_n, sclk, din, ready, done} in cycle n of a frame (start sampled in cycle 0).
  function automatic logic [4:0] exp_out(input int d, input logic [9:0] code, input int n);
    logic [11:0] w;
    logic e_cs, e_sclk, e_din, e_rdy, e_done;
    w      = {code, 2'b00};
    e_cs   = !(n >= 1 && n < 1 + 25 * d);
    e_sclk = (n >= 1 && n < 1 + 24 * d) ? (((n - 1) / d) % 2 == 1) : 1'b0;
    e_din  = (n >= 1 && n < 1 + 24 * d) ? w[11 - ((n - 1) / (2 * d))] : 1'b0;
    e_rdy  = (n >= 1 + 26 * d);
    e_done = (n == 1 + 26 * d);
    return {e_cs, e_sclk, e_din, e_rdy, e_done};
  endfunction

  function automatic logic [9:0] fresh_code();
    logic [9:0] c;
    c = 10'($urandom);
    if (last_vld && c == last_code) c = c ^ 10'h001;
    return c;
  endfunction

  // Issues a write at the current negedge and checks the whole frame, ending at the
  // negedge of the cycle where ready returns (so a caller can chain the next write).
  task automatic run_frame(input logic [9:0] code, input bit keep_start,
                           input int poke_n, input logic [9:0] poke_code);
    int last_n = 1 + 26 * D1;
    int bad = 0, first_bad = -1, rises = 0, cs_low = 0, dones = 0;
    logic [4:0] got, exp, bad_got, bad_exp;
    logic [11:0] dec = '0;
    logic prev_sclk = 1'b0;
    bad_got = '0;
    bad_exp = '0;
    din   = code;
    start = 1'b1;
    for (int n = 1; n <= last_n; n++) begin
      @(negedge clk);
      if (n == 1) begin
        start    = keep_start;
        frame_t0 = cyc;
      end
      if (n == poke_n) begin
        start = 1'b1;
        din   = poke_code;
      end else if (n == poke_n + 1) begin
        start = keep_start;
        din   = code;
      end
      got = {cs_n, sclk, sdi, ready, done};
      exp = exp_out(D1, code, n);
      if (got !== exp) begin
        bad++;
        if (first_bad < 0) begin
          first_bad = n;
          bad_got   = got;
          bad_exp   = exp;
        end
      end
      if (sclk && !prev_sclk) begin
        if (rises < 12) dec[11 - rises] = sdi;
        rises++;
      end
      prev_sclk = sclk;
      if (!cs_n) cs_low++;
      if (done) dones++;
    end
    checks++;
    if (bad != 0) begin
      failures++;
      $display("FAIL frame_wave code=%h first_cycle=%0d got=%b exp=%b bad_cycles=%0d",
               code, first_bad, bad_got, bad_exp, bad);
    end
    checks++;
    if (rises !== 12) begin
      failures++;
      $display("FAIL sclk_rises code=%h got=%0d exp=12", code, rises);
    end
    checks++;
    if (dec !== {code, 2'b00}) begin
      failures++;
      $display("FAIL decode got=%h exp=%h", dec, {code, 2'b00});
    end
    checks++;
    if (cs_low !== 25 * D1) begin
      failures++;
      $display("FAIL cs_low_len code=%h got=%0d exp=%0d", code, cs_low, 25 * D1);
    end
    checks++;
    if (dones !== 1) begin
      failures++;
      $display("FAIL done_count code=%h got=%0d exp=1", code, dones);
    end
    last_code = code;
    last_vld  = 1'b1;
  endtask

  task automatic idle(input int k, input string name);
    int bad = 0;
    start = 1'b0;
    for (int i = 0; i < k; i++) begin
      @(negedge clk);
      if ({cs_n, sclk, sdi, ready, done} !== 5'b10010) bad++;
    end
    checks++;
    if (bad != 0) begin
      failures++;
      $display("FAIL %s got=%0d bad idle cycles exp=0", name, bad);
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (3) @(negedge clk);
    checks++;
    if ({cs_n, sclk, sdi, ready, done} !== 5'b10010) begin
      failures++;
      $display("FAIL reset_state got=%b exp=10010", {cs_n, sclk, sdi, ready, done});
    end
    checks++;
    if ({cs_n2, sclk2, sdi2, ready2, done2} !== 5'b10010) begin
      failures++;
      $display("FAIL reset_state_div2 got=%b exp=10010", {cs_n2, sclk2, sdi2, ready2, done2});
    end
    reset    = 1'b0;
    last_vld = 1'b0;
    idle(3, "post_reset_idle");
  endtask

  task automatic test_single();
    run_frame(10'h2A5, 1'b0, -5, 10'h0);
    idle(5, "single_tail_idle");
  endtask

  task automatic test_back_to_back();
    int t0, t1, t2;
    run_frame(10'h3FF, 1'b1, -5, 10'h0);
    t0 = frame_t0;
    run_frame(10'h000, 1'b1, -5, 10'h0);
    t1 = frame_t0;
    run_frame(10'h155, 1'b0, -5, 10'h0);
    t2 = frame_t0;
    checks++;
    if ((t1 - t0) !== 26 * D1 + 1 || (t2 - t1) !== 26 * D1 + 1) begin
      failures++;
      $display("FAIL b2b_period got=%0d,%0d exp=%0d", t1 - t0, t2 - t1, 26 * D1 + 1);
    end
    idle(5, "b2b_tail_idle");
  endtask

  task automatic test_busy_poke();
    run_frame(fresh_code(), 1'b0, 300, 10'h111);
    idle(30, "poke_no_second_frame");
  endtask

  task automatic test_reset_mid();
    din   = fresh_code();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (199) @(negedge clk);
    checks++;
    if (cs_n !== 1'b0) begin
      failures++;
      $display("FAIL mid_frame_active got=%b exp=0", cs_n);
    end
    reset = 1'b1;
    #1;
    checks++;
    if ({cs_n, sclk, sdi, ready, done} !== 5'b10010) begin
      failures++;
      $display("FAIL async_reset got=%b exp=10010", {cs_n, sclk, sdi, ready, done});
    end
    @(negedge clk);
    reset    = 1'b0;
    last_vld = 1'b0;
    idle(3, "reset_mid_idle");
    run_frame(fresh_code(), 1'b0, -5, 10'h0);
    idle(2, "reset_mid_tail");
  endtask

  task automatic test_random();
    for (int i = 0; i < 4; i++) begin
      int gap, pn;
      gap = $urandom_range(0, 4);
      pn  = ($urandom_range(0, 1) == 1) ? $urandom_range(2, 26 * D1) : -5;
      if (gap > 0) idle(gap, "random_gap");
      run_frame(fresh_code(), 1'b0, pn, 10'($urandom));
    end
    idle(3, "random_tail");
  endtask

  task automatic test_div2();
    int bad = 0, rises = 0, done_n = -1, r0 = -1, r1 = -1;
    logic [11:0] dec = '0;
    logic prev = 1'b0;
    din2   = 10'h001;
    start2 = 1'b1;
    for (int n = 1; n <= 1 + 26 * D2; n++) begin
      @(negedge clk);
      start2 = 1'b0;
      if ({cs_n2, sclk2, sdi2, ready2, done2} !== exp_out(D2, 10'h001, n)) bad++;
      if (sclk2 && !prev) begin
        if (rises == 0) r0 = n;
        if (rises == 1) r1 = n;
        if (rises < 12) dec[11 - rises] = sdi2;
        rises++;
      end
      prev = sclk2;
      if (done2 && done_n < 0) done_n = n;
    end
    checks++;
    if (bad != 0) begin
      failures++;
      $display("FAIL div2_wave got=%0d bad cycles exp=0", bad);
    end
    checks++;
    if (rises !== 12 || dec[2] !== 1'b1 || dec[11:3] !== 9'h0) begin
      failures++;
      $display("FAIL div2_bits rises=%0d got=%h exp=004", rises, dec);
    end
    checks++;
    if ((r1 - r0) !== 4) begin
      failures++;
      $display("FAIL div2_sclk_period got=%0d exp=4", r1 - r0);
    end
    checks++;
    if (done_n !== 53) begin
      failures++;
      $display("FAIL div2_done_cycle got=%0d exp=53", done_n);
    end
  endtask

`ifdef TLC5615_SKIP_SAME_EN
  task automatic test_skip_same();
    reset = 1'b1;
    @(negedge clk);
    reset    = 1'b0;
    last_vld = 1'b0;
    idle(2, "skip_pre_idle");
    run_frame(10'h0F0, 1'b0, -5, 10'h0);
    din   = 10'h0F0;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    checks++;
    if ({cs_n, sclk, sdi, ready, done} !== 5'b10011) begin
      failures++;
      $display("FAIL skip_done got=%b exp=10011", {cs_n, sclk, sdi, ready, done});
    end
    idle(2 * D1, "skip_no_bus_activity");
    reset = 1'b1;
    @(negedge clk);
    reset    = 1'b0;
    last_vld = 1'b0;
    idle(2, "skip_post_reset");
    run_frame(10'h0F0, 1'b0, -5, 10'h0);
    idle(2, "skip_tail");
  endtask
`else
  task automatic test_same_code();
    logic [9:0] c;
    c = fresh_code();
    run_frame(c, 1'b0, -5, 10'h0);
    run_frame(c, 1'b0, -5, 10'h0);
    idle(2, "same_code_tail");
  endtask
`endif

  initial begin
    reset  = 1'b1;
    start  = 1'b0;
    din    = '0;
    start2 = 1'b0;
    din2   = '0;
    @(negedge clk);
    test_reset();
    test_single();
    test_back_to_back();
    test_busy_poke();
    test_reset_mid();
    test_random();
    test_div2();
`ifdef TLC5615_SKIP_SAME_EN
    test_skip_same();
`else
    test_same_code();
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
